mem_responder: RTL
==================

Name: mem_responder

Overview:
- Synchronous memory server: the responder end of the memory request/response interface driven by the load/store execute units.
- Accepts read/write requests over val/rdy, applies them to an internal word array, and returns in-order responses after a fixed latency.
- Buffers responses under back-pressure.
- Serves as the simulation/FPGA data memory behind the execute stage.

Parameters:
- p_opaq_bits, 8, width of the opaque field echoed from request to response
- p_num_words, 256, storage depth in 32-bit words; power of two, ≥ 2
- p_latency, 1, cycles from request acceptance to earliest resp_val; range 1..8
- p_resp_depth, 4, maximum outstanding requests (in latency pipe plus response queue); ≥ p_latency

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_val  in  1  request valid
- req_rdy  out  1  request ready
- req_op  in  1  t_op: MEM_MSG_READ / MEM_MSG_WRITE
- req_opaque  in  p_opaq_bits  tag, echoed in response
- req_addr  in  32  byte address
- req_strb  in  4  byte enables for writes
- req_data  in  32  write data
- resp_val  out  1  response valid
- resp_rdy  in  1  response ready
- resp_op  out  1  echoed op
- resp_opaque  out  p_opaq_bits  echoed opaque
- resp_addr  out  32  echoed address
- resp_strb  out  4  echoed strobe
- resp_data  out  32  read data; 0 for writes
- init_en  in  1  back-door write enable, used by test loaders
- init_addr  in  32  back-door byte address
- init_data  in  32  back-door word, all bytes written

Interface note: the req_* and resp_* signals are the server side of the memory interface. One clock, clk. Reset rst is synchronous and active-high.

Behaviour:
- Reset values:
  - Outstanding count 0; latency pipe and response queue empty.
  - resp_val = 0; resp_* payload don't-care.
  - req_rdy = 0 while rst is high and 1 in the first cycle after reset.
  - Storage contents are not cleared by reset.
- Indexing: word index = addr[2 +: log2(p_num_words)]. Upper bits and addr[1:0] are ignored, so addresses wrap modulo 4*p_num_words.
- Acceptance:
  - A request is accepted when req_val & req_rdy at posedge.
  - req_rdy = (outstanding < p_resp_depth). It has no combinational dependence on resp_rdy or req_val.
  - When full, a same-cycle dequeue does not admit a new request; the slot frees the following cycle.
- Write at acceptance: for each byte i with strb[i]=1, storage byte i = data byte i. Bytes with strb[i]=0 are unchanged.
- Read at acceptance: storage is sampled in the acceptance cycle.
  - Read-after-write to the same word in consecutive accepted requests returns the new data.
  - A read accepted in the same cycle as a write (impossible, single port) does not apply.
- Latency pipe: p_latency-stage shift register of {val, op, opaque, addr, strb, data}, advancing every cycle. Stage p_latency output enqueues into a response FIFO of depth p_resp_depth.
- Response: resp_val = FIFO non-empty; payload = FIFO head. Dequeue on resp_val & resp_rdy.
  - Minimum latency: accepted at edge N, resp_val high in cycle N+p_latency.
  - Back-to-back acceptances with resp_rdy=1 give one response per cycle.
- Ordering: strictly in order. outstanding increments on accept and decrements on dequeue; both in the same cycle leaves it unchanged.
- init_en:
  - Writes the full word at edge; it has priority over a same-word request write in the same cycle.
  - It does not affect handshakes.
  - It is legal during rst.
- Reset mid-operation: all in-flight and queued responses are discarded; storage writes already performed persist.

Optional Feature:
- Macro: MEM_RESPONDER_STALL_EN.
- When defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4) is reset to 8'hA5 and advances every cycle.
  - req_rdy is additionally forced to 0 whenever lfsr[1:0]==2'b00.
  - This provides deterministic pseudo-random back-pressure for stressing initiators; all other behaviour is unchanged.
- When undefined: no LFSR exists, and req_rdy follows the base rule only.

Test Plan:
- Write then read, p_latency=1:
  - Write addr 0x10, data 0xDEADBEEF, strb 4'hF, opaque 8'h01 -> next cycle resp op=WRITE, opaque 01, data 0.
  - Then read 0x10 -> response data 0xDEADBEEF, addr 0x10.
- Partial strobe:
  - init word 4 = 0x11223344; write addr 0x10, data 0xAABBCCDD, strb 4'b0101; read 0x10 -> 0x11BB33DD.
- Back-pressure fill, p_resp_depth=4:
  - resp_rdy=0, issue 5 reads -> 4 accepted, then req_rdy=0.
  - Raise resp_rdy -> 4 responses in order, req_rdy returns to 1 the cycle after the first dequeue.
- Throughput, p_latency=3:
  - 8 back-to-back reads with resp_rdy=1 -> first resp_val 3 cycles after the first accept, then 8 consecutive cycles of responses with opaque 0..7.
- Wrap, p_num_words=256:
  - Write 0x400 with 0x12345678; read 0x000 -> 0x12345678.
- Reset mid-flight:
  - Accept 2 reads, assert rst one cycle -> resp_val stays 0, req_rdy 1 after reset, storage intact on re-read.

Source files
------------

// File: rtl/mem_responder_if.sv
// Memory request/response bus between execute-stage initiators and the data memory.
// master = initiator side, slave = responder side.
interface mem_responder_if #(
  parameter int p_opaq_bits = 8
);
  logic                   req_val;
  logic                   req_rdy;
  logic                   req_op;
  logic [p_opaq_bits-1:0] req_opaque;
  logic [31:0]            req_addr;
  logic [3:0]             req_strb;
  logic [31:0]            req_data;

  logic                   resp_val;
  logic                   resp_rdy;
  logic                   resp_op;
  logic [p_opaq_bits-1:0] resp_opaque;
  logic [31:0]            resp_addr;
  logic [3:0]             resp_strb;
  logic [31:0]            resp_data;

  modport master (
    output req_val, req_op, req_opaque,
    output req_addr, req_strb, req_data,
    output resp_rdy,
    input  req_rdy,
    input  resp_val, resp_op, resp_opaque,
    input  resp_addr, resp_strb, resp_data
  );

  modport slave (
    input  req_val, req_op, req_opaque,
    input  req_addr, req_strb, req_data,
    input  resp_rdy,
    output req_rdy,
    output resp_val, resp_op, resp_opaque,
    output resp_addr, resp_strb, resp_data
  );
endinterface

// File: rtl/mem_responder.sv
// Fixed-latency in-order memory responder with a response FIFO.
// Optional macro MEM_RESPONDER_STALL_EN adds LFSR-driven request back-pressure.
module mem_responder #(
  parameter int p_opaq_bits  = 8,
  parameter int p_num_words  = 256,
  parameter int p_latency    = 1,
  parameter int p_resp_depth = 4
) (
  input  logic             clk,
  input  logic             rst,
  mem_responder_if.slave   mem,
  input  logic             init_en,
  input  logic [31:0]      init_addr,
  input  logic [31:0]      init_data
);

  typedef enum logic {
    MEM_MSG_READ  = 1'b0,
    MEM_MSG_WRITE = 1'b1
  } t_op;

  typedef struct packed {
    logic                   op;
    logic [p_opaq_bits-1:0] opaque;
    logic [31:0]            addr;
    logic [3:0]             strb;
    logic [31:0]            data;
  } msg_t;

  localparam int IW = $clog2(p_num_words);
  localparam int PW = (p_resp_depth > 1) ? $clog2(p_resp_depth) : 1;
  localparam int CW = $clog2(p_resp_depth + 1);

  logic [31:0]   mem_q [p_num_words];
  msg_t          fifo_q [p_resp_depth];

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] fcnt_q, fcnt_d;
  logic [CW-1:0] outst_q, outst_d;

  logic          stall;
  logic          req_rdy;
  logic          resp_val;
  logic          accept;
  logic          deq;
  logic          wr_en;
  logic [IW-1:0] req_idx;
  logic [IW-1:0] init_idx;
  logic [31:0]   rd_word;
  logic [31:0]   wr_word;
  msg_t          in_msg;
  logic          enq_val;
  msg_t          enq_msg;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^{init_addr[31:2+IW], init_addr[1:0]};

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(p_resp_depth - 1)) ? '0 : p + PW'(1);
  endfunction

`ifdef MEM_RESPONDER_STALL_EN
  logic [7:0] lfsr_q, lfsr_d;

  // Fibonacci LFSR step, taps 8,6,5,4.
  always_comb begin
    lfsr_d = {lfsr_q[6:0],
              lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  // LFSR register, seeded on reset.
  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= 8'hA5;
    else     lfsr_q <= lfsr_d;
  end

  assign stall = (lfsr_q[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  // Handshakes, storage access and the accepted message.
  always_comb begin
    req_rdy  = ~rst & (outst_q < CW'(p_resp_depth)) & ~stall;
    accept   = mem.req_val & req_rdy;
    resp_val = ~rst & (fcnt_q != '0);
    deq      = resp_val & mem.resp_rdy;
    req_idx  = mem.req_addr[2 +: IW];
    init_idx = init_addr[2 +: IW];
    rd_word  = mem_q[req_idx];
    wr_en    = accept & (mem.req_op == MEM_MSG_WRITE);
    wr_word  = rd_word;
    for (int i = 0; i < 4; i++) begin
      if (mem.req_strb[i]) wr_word[8*i +: 8] = mem.req_data[8*i +: 8];
    end
    in_msg.op     = mem.req_op;
    in_msg.opaque = mem.req_opaque;
    in_msg.addr   = mem.req_addr;
    in_msg.strb   = mem.req_strb;
    in_msg.data   = (mem.req_op == MEM_MSG_WRITE) ? '0 : rd_word;
  end

  // Storage: request write first so a same-word init wins.
  always_ff @(posedge clk) begin
    if (wr_en)   mem_q[req_idx]  <= wr_word;
    if (init_en) mem_q[init_idx] <= init_data;
  end

  generate
    if (p_latency == 1) begin : g_nopipe
      assign enq_val = accept;
      assign enq_msg = in_msg;
    end else begin : g_pipe
      logic [p_latency-2:0] pv_q, pv_d;
      msg_t                 pm_q [p_latency-1];
      msg_t                 pm_d [p_latency-1];

      // Shift the accepted message down the delay line.
      always_comb begin
        pv_d[0] = accept;
        pm_d[0] = in_msg;
        for (int i = 1; i < p_latency - 1; i++) begin
          pv_d[i] = pv_q[i-1];
          pm_d[i] = pm_q[i-1];
        end
      end

      // Delay-line valid bits, dropped on reset.
      always_ff @(posedge clk) begin
        if (rst) pv_q <= '0;
        else     pv_q <= pv_d;
      end

      // Delay-line payload, no reset needed.
      always_ff @(posedge clk) begin
        for (int i = 0; i < p_latency - 1; i++) begin
          pm_q[i] <= pm_d[i];
        end
      end

      assign enq_val = pv_q[p_latency-2];
      assign enq_msg = pm_q[p_latency-2];
    end
  endgenerate

  // FIFO pointers, fill level and outstanding count.
  always_comb begin
    wptr_d  = enq_val ? ptr_inc(wptr_q) : wptr_q;
    rptr_d  = deq ? ptr_inc(rptr_q) : rptr_q;
    fcnt_d  = fcnt_q;
    outst_d = outst_q;
    unique case ({enq_val, deq})
      2'b10:   fcnt_d = fcnt_q + CW'(1);
      2'b01:   fcnt_d = fcnt_q - CW'(1);
      default: fcnt_d = fcnt_q;
    endcase
    unique case ({accept, deq})
      2'b10:   outst_d = outst_q + CW'(1);
      2'b01:   outst_d = outst_q - CW'(1);
      default: outst_d = outst_q;
    endcase
  end

  // Control state, cleared on reset to discard in-flight work.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      fcnt_q  <= '0;
      outst_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      fcnt_q  <= fcnt_d;
      outst_q <= outst_d;
    end
  end

  // FIFO storage write at the tail.
  always_ff @(posedge clk) begin
    if (enq_val & ~rst) fifo_q[wptr_q] <= enq_msg;
  end

  assign mem.req_rdy     = req_rdy;
  assign mem.resp_val    = resp_val;
  assign mem.resp_op     = fifo_q[rptr_q].op;
  assign mem.resp_opaque = fifo_q[rptr_q].opaque;
  assign mem.resp_addr   = fifo_q[rptr_q].addr;
  assign mem.resp_strb   = fifo_q[rptr_q].strb;
  assign mem.resp_data   = fifo_q[rptr_q].data;

endmodule
